// File: rtl/serial_xfer_controller_if.sv
// Bundle of datapath status inputs and enable/debug outputs for serial_xfer_controller.
// The slave modport is the controller's view; the master modport is the datapath/bench view.
interface serial_xfer_controller_if #(
  parameter int FRAME_W = 8
);
  logic               clkEn;
  logic               serIn;
  logic               co1;
  logic               co2;
  logic               coD;
  logic               numZero;
  logic               abort;
  logic               shEn;
  logic               cnt1;
  logic               shEnD;
  logic               cnt2;
  logic               ldCntD;
  logic               cntD;
  logic               serCntValid;
  logic               Done;
  logic               busy;
  logic [2:0]         state;
  logic [FRAME_W-1:0] frameCnt;

  modport master (
    output clkEn, serIn, co1, co2, coD, numZero, abort,
    input  shEn, cnt1, shEnD, cnt2, ldCntD, cntD, serCntValid, Done, busy, state, frameCnt
  );

  modport slave (
    input  clkEn, serIn, co1, co2, coD, numZero, abort,
    output shEn, cnt1, shEnD, cnt2, ldCntD, cntD, serCntValid, Done, busy, state, frameCnt
  );
endinterface

// File: rtl/serial_xfer_controller.sv
// Frame-sequencing FSM for the serial port-demux datapath: start, port bits, count bits,
// counter load, data transfer, completion pulse; plus a saturating completed-frame counter.
module serial_xfer_controller #(
  parameter int   FRAME_W   = 8,
  parameter logic START_LVL = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_xfer_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PORT = 3'd1,
    S_NUM  = 3'd2,
    S_LOAD = 3'd3,
    S_DATA = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [FRAME_W-1:0] r_frameCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (bus.clkEn && (bus.serIn == START_LVL)) w_next = S_PORT;
        S_PORT: if (bus.clkEn && bus.co1)                  w_next = S_NUM;
        S_NUM:  if (bus.clkEn && bus.co2)                  w_next = S_LOAD;
        S_LOAD: if (bus.clkEn) w_next = bus.numZero ? S_DONE : S_DATA;
        S_DATA: if (bus.clkEn && bus.coD)                  w_next = S_DONE;
        S_DONE: w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Moore decode: every output depends on r_state alone.
  always_comb begin
    bus.shEn        = 1'b0;
    bus.cnt1        = 1'b0;
    bus.shEnD       = 1'b0;
    bus.cnt2        = 1'b0;
    bus.ldCntD      = 1'b0;
    bus.cntD        = 1'b0;
    bus.serCntValid = 1'b0;
    bus.Done        = 1'b0;
    case (r_state)
      S_PORT: begin
        bus.shEn = 1'b1;
        bus.cnt1 = 1'b1;
      end
      S_NUM: begin
        bus.shEnD = 1'b1;
        bus.cnt2  = 1'b1;
      end
      S_LOAD: bus.ldCntD = 1'b1;
      S_DATA: begin
        bus.cntD        = 1'b1;
        bus.serCntValid = 1'b1;
      end
      S_DONE: bus.Done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frameCnt <= '0;
    end else if ((w_next == S_DONE) && (r_state != S_DONE) && (r_frameCnt != '1)) begin
      r_frameCnt <= r_frameCnt + 1'b1;
    end
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.state    = r_state;
  assign bus.frameCnt = r_frameCnt;

endmodule
